// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD hex streamer family.
// Holds the ASCII pieces used to build characters and the frame FSM states.
package lcd_pkg;

    localparam logic [7:0] ASCII_SPACE       = 8'h20;
    localparam logic [3:0] ASCII_DIGIT_HI    = 4'h3;
    localparam logic [3:0] ASCII_ALPHA_HI_UC = 4'h4;
    localparam logic [3:0] ASCII_ALPHA_HI_LC = 4'h6;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } state_e;

    // Index width for a counter covering 0..n-1, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Converts one hex nibble into the two ASCII nibbles of its character.
// Digits 0-9 map to 0x30-0x39, A-F to 0x41-0x46 or 0x61-0x66.
module hex_nibble_to_ascii
    import lcd_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       lowercase_i,
    output logic [3:0] up_o,
    output logic [3:0] low_o
);

    // Letters start at 0x41/0x61, so value 10 lands on low nibble 1.
    always_comb begin
        up_o  = ASCII_DIGIT_HI;
        low_o = nibble_i;
        if (nibble_i >= 4'd10) begin
            up_o  = lowercase_i ? ASCII_ALPHA_HI_LC : ASCII_ALPHA_HI_UC;
            low_o = nibble_i - 4'd9;
        end
    end

endmodule

// File: rtl/lcd_hex_streamer.sv
// Snapshots a set of words on start and streams them to the LCD write
// controller as ASCII hex characters over a valid/ready handshake, with
// optional word separators, leading-zero blanking and lowercase letters.
// WORD_W must be a multiple of 4.
module lcd_hex_streamer
    import lcd_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 2,
    parameter int SEP_EN    = 1,
    parameter int LOWERCASE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          blank_lz,
    input  logic [NUM_WORDS*WORD_W-1:0]   words_in,
    output logic                          busy,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic [3:0]                    char_up,
    output logic [3:0]                    char_low,
    output logic                          char_last,
    output logic                          done
);

    localparam int D      = WORD_W / 4;
    localparam int DIG_W  = idxWidth(D);
    localparam int WIDX_W = idxWidth(NUM_WORDS);
    localparam int DIG_SLOTS  = 2 ** DIG_W;
    localparam int WORD_SLOTS = 2 ** WIDX_W;
    localparam logic [DIG_W-1:0]  DIG_MAX  = DIG_W'(D - 1);
    localparam logic [WIDX_W-1:0] WORD_MAX = WIDX_W'(NUM_WORDS - 1);
    localparam logic              LC_MODE  = (LOWERCASE != 0);

    state_e                        state_q;
    logic [NUM_WORDS*WORD_W-1:0]   snapWords_q;
    logic                          blankLz_q;
    logic [WIDX_W-1:0]             wordIdx_q;
    logic [DIG_W-1:0]              digIdx_q;
    logic                          onSep_q;
    logic                          seenNz_q;
    logic [3:0]                    charUp_q;
    logic [3:0]                    charLow_q;
    logic                          charValid_q;
    logic                          charLast_q;
    logic                          busy_q;
    logic                          done_q;

    logic [WIDX_W-1:0]             nxtWord_d;
    logic [DIG_W-1:0]              nxtDig_d;
    logic                          nxtSep_d;
    logic                          nxtSeenIn_d;
    logic [NUM_WORDS*WORD_W-1:0]   srcWords_d;
    logic                          srcBlank_d;

    logic [WORD_W-1:0]             wordArr [WORD_SLOTS];
    logic [3:0]                    digArr  [DIG_SLOTS];
    logic [WORD_W-1:0]             curWord;
    logic [3:0]                    nibble;
    logic [3:0]                    hexUp;
    logic [3:0]                    hexLow;

    logic [3:0]                    genUp_d;
    logic [3:0]                    genLow_d;
    logic                          genSeen_d;
    logic                          genLast_d;

    logic                          xfer;

    // Work out which character position is loaded next: position 0 from the
    // live inputs when idle, otherwise the one after the character on show.
    always_comb begin
        nxtWord_d   = wordIdx_q;
        nxtDig_d    = digIdx_q;
        nxtSep_d    = 1'b0;
        nxtSeenIn_d = seenNz_q;
        srcWords_d  = snapWords_q;
        srcBlank_d  = blankLz_q;
        if (state_q == IDLE) begin
            nxtWord_d   = '0;
            nxtDig_d    = DIG_MAX;
            nxtSeenIn_d = 1'b0;
            srcWords_d  = words_in;
            srcBlank_d  = blank_lz;
        end else if (onSep_q) begin
            nxtWord_d   = wordIdx_q + 1'b1;
            nxtDig_d    = DIG_MAX;
            nxtSeenIn_d = 1'b0;
        end else if (digIdx_q != '0) begin
            nxtDig_d    = digIdx_q - 1'b1;
        end else if (SEP_EN != 0) begin
            nxtSep_d    = 1'b1;
        end else begin
            nxtWord_d   = wordIdx_q + 1'b1;
            nxtDig_d    = DIG_MAX;
            nxtSeenIn_d = 1'b0;
        end
    end

    // Unpack words and digits into power-of-two arrays so the index
    // counters can address them without running off the end.
    for (genvar gw = 0; gw < WORD_SLOTS; gw++) begin : g_words
        if (gw < NUM_WORDS) begin : g_real
            assign wordArr[gw] = srcWords_d[gw*WORD_W +: WORD_W];
        end else begin : g_pad
            assign wordArr[gw] = '0;
        end
    end

    assign curWord = wordArr[nxtWord_d];

    for (genvar gd = 0; gd < DIG_SLOTS; gd++) begin : g_digits
        if (gd < D) begin : g_real
            assign digArr[gd] = curWord[gd*4 +: 4];
        end else begin : g_pad
            assign digArr[gd] = 4'h0;
        end
    end

    assign nibble = digArr[nxtDig_d];

    hex_nibble_to_ascii u_hex (
        .nibble_i    (nibble),
        .lowercase_i (LC_MODE),
        .up_o        (hexUp),
        .low_o       (hexLow)
    );

    // Pick the final character: separator, blanked leading zero or digit.
    // The last digit of a word is never blanked so a zero word shows "0".
    always_comb begin
        genUp_d   = hexUp;
        genLow_d  = hexLow;
        genSeen_d = nxtSeenIn_d | (nibble != 4'h0);
        genLast_d = (nxtWord_d == WORD_MAX) && (nxtDig_d == '0) && !nxtSep_d;
        if (nxtSep_d) begin
            {genUp_d, genLow_d} = ASCII_SPACE;
            genSeen_d           = 1'b0;
        end else if (srcBlank_d && !nxtSeenIn_d && (nibble == 4'h0) && (nxtDig_d != '0)) begin
            {genUp_d, genLow_d} = ASCII_SPACE;
        end
    end

    assign xfer = charValid_q && char_ready;

    // Frame FSM with registered outputs; the presented character only
    // changes on a transfer, so stalls hold it stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snapWords_q <= '0;
            blankLz_q   <= 1'b0;
            wordIdx_q   <= '0;
            digIdx_q    <= '0;
            onSep_q     <= 1'b0;
            seenNz_q    <= 1'b0;
            charUp_q    <= 4'h0;
            charLow_q   <= 4'h0;
            charValid_q <= 1'b0;
            charLast_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        snapWords_q <= words_in;
                        blankLz_q   <= blank_lz;
                        wordIdx_q   <= nxtWord_d;
                        digIdx_q    <= nxtDig_d;
                        onSep_q     <= nxtSep_d;
                        seenNz_q    <= genSeen_d;
                        charUp_q    <= genUp_d;
                        charLow_q   <= genLow_d;
                        charLast_q  <= genLast_d;
                        charValid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (charLast_q) begin
                            charValid_q <= 1'b0;
                            charLast_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= FIN;
                        end else begin
                            wordIdx_q   <= nxtWord_d;
                            digIdx_q    <= nxtDig_d;
                            onSep_q     <= nxtSep_d;
                            seenNz_q    <= genSeen_d;
                            charUp_q    <= genUp_d;
                            charLow_q   <= genLow_d;
                            charLast_q  <= genLast_d;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign char_valid = charValid_q;
    assign char_up    = charUp_q;
    assign char_low   = charLow_q;
    assign char_last  = charLast_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lcd_hex_streamer.sv
// Bench for lcd_hex_streamer: a default-parameter instance plus a narrow
// lowercase instance without separators. Expected characters are queued
// when a frame is requested and compared against the captured stream.
module tb_lcd_hex_streamer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        startA, blankA, readyA;
    logic [31:0] wordsA;
    logic        busyA, validA, lastA, doneA;
    logic [3:0]  upA, lowA;

    logic        startB, blankB, readyB;
    logic [31:0] wordsB;
    logic        busyB, validB, lastB, doneB;
    logic [3:0]  upB, lowB;

    int errors = 0;
    int checks = 0;

    logic [8:0] expQ[$];
    logic [8:0] obsQ[$];

    int doneCnt, busyCnt, stallErr, lastXferCyc, doneCyc;
    bit timedOut;

    lcd_hex_streamer #(
        .WORD_W(16), .NUM_WORDS(2), .SEP_EN(1), .LOWERCASE(0)
    ) dutA (
        .clk        (clk),
        .rst        (rst),
        .start      (startA),
        .blank_lz   (blankA),
        .words_in   (wordsA),
        .busy       (busyA),
        .char_valid (validA),
        .char_ready (readyA),
        .char_up    (upA),
        .char_low   (lowA),
        .char_last  (lastA),
        .done       (doneA)
    );

    lcd_hex_streamer #(
        .WORD_W(8), .NUM_WORDS(4), .SEP_EN(0), .LOWERCASE(1)
    ) dutB (
        .clk        (clk),
        .rst        (rst),
        .start      (startB),
        .blank_lz   (blankB),
        .words_in   (wordsB),
        .busy       (busyB),
        .char_valid (validB),
        .char_ready (readyB),
        .char_up    (upB),
        .char_low   (lowB),
        .char_last  (lastB),
        .done       (doneB)
    );

    // Queue one expected character as {last, up, low}.
    task automatic pushExp(input logic [7:0] ch, input logic last);
        expQ.push_back({last, ch});
    endtask

    // Drive dutA for one frame and record every transferred character,
    // stall stability violations, busy cycles and the done pulse.
    task automatic applyStimulus(input bit randReady, input bit holdStart, input int maxXfer,
                                 input int maxCycles, input bit midChange, input logic [31:0] midWords);
        bit pv, pr, finished;
        logic [8:0] pc;
        obsQ.delete();
        doneCnt = 0; busyCnt = 0; stallErr = 0; lastXferCyc = -1; doneCyc = -1;
        timedOut = 0; finished = 0; pv = 0; pr = 0; pc = '0;
        for (int cyc = 1; cyc <= maxCycles && !finished; cyc++) begin
            @(negedge clk);
            if (!holdStart) startA = 1'b0;
            if (midChange && cyc == 3) wordsA = midWords;
            readyA = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr && (!validA || {lastA, upA, lowA} !== pc)) stallErr++;
            if (busyA) busyCnt++;
            if (validA && readyA) begin
                obsQ.push_back({lastA, upA, lowA});
                lastXferCyc = cyc;
                if (obsQ.size() >= maxXfer) finished = 1;
            end
            if (doneA) begin
                doneCnt++;
                doneCyc  = cyc;
                finished = 1;
            end
            pv = validA; pr = readyA; pc = {lastA, upA, lowA};
        end
        if (!finished) timedOut = 1;
    endtask

    task automatic queueFrame1();
        logic [7:0] c [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h20, 8'h30, 8'h30, 8'h41, 8'h46};
        expQ.delete();
        for (int i = 0; i < 9; i++) pushExp(c[i], i == 8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busyA, validA, lastA, doneA, upA, lowA} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL resetA: got %h expected 000", {busyA, validA, lastA, doneA, upA, lowA});
        end
        checks++;
        if ({busyB, validB, lastB, doneB, upB, lowB} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL resetB: got %h expected 000", {busyB, validB, lastB, doneB, upB, lowB});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        @(negedge clk);
        wordsA = 32'h00AF_1234; blankA = 1'b0; startA = 1'b1;
        queueFrame1();
        applyStimulus(0, 0, 100, 60, 0, '0);
        checks++;
        if (timedOut) begin errors++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL basic_count: got %0d expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            logic [8:0] o, e;
            o = obsQ.pop_front(); e = expQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL basic_char: got %h expected %h", o, e); end
        end
        checks++;
        if (busyCnt !== 10) begin errors++; $display("[TB] FAIL basic_busy: got %0d expected 10", busyCnt); end
        checks++;
        if (doneCnt !== 1) begin errors++; $display("[TB] FAIL basic_done: got %0d expected 1", doneCnt); end
        checks++;
        if (doneCyc - lastXferCyc !== 1) begin
            errors++; $display("[TB] FAIL basic_done_lat: got %0d expected 1", doneCyc - lastXferCyc);
        end
    endtask

    task automatic test_blanking();
        logic [7:0] c [9] = '{8'h20, 8'h20, 8'h41, 8'h30, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30};
        @(negedge clk);
        wordsA = 32'h0000_00A0; blankA = 1'b1; startA = 1'b1;
        expQ.delete();
        for (int i = 0; i < 9; i++) pushExp(c[i], i == 8);
        applyStimulus(0, 0, 100, 60, 0, '0);
        blankA = 1'b0;
        checks++;
        if (timedOut || obsQ.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL blank_count: got %0d expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            logic [8:0] o, e;
            o = obsQ.pop_front(); e = expQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL blank_char: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        wordsA = 32'h00AF_1234; startA = 1'b1;
        queueFrame1();
        applyStimulus(1, 0, 100, 400, 0, '0);
        readyA = 1'b1;
        checks++;
        if (timedOut || obsQ.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            logic [8:0] o, e;
            o = obsQ.pop_front(); e = expQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL bp_char: got %h expected %h", o, e); end
        end
        checks++;
        if (stallErr !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", stallErr); end
        checks++;
        if (doneCnt !== 1) begin errors++; $display("[TB] FAIL bp_done: got %0d expected 1", doneCnt); end
    endtask

    task automatic test_start_held();
        logic [7:0] c2 [9] = '{8'h39, 8'h41, 8'h42, 8'h43, 8'h20, 8'h35, 8'h36, 8'h37, 8'h38};
        @(negedge clk);
        wordsA = 32'h00AF_1234; startA = 1'b1;
        queueFrame1();
        applyStimulus(0, 1, 100, 60, 1, 32'h5678_9ABC);
        checks++;
        if (timedOut || obsQ.size() !== expQ.size() || doneCnt !== 1) begin
            errors++; $display("[TB] FAIL held_frame1: got %0d chars %0d done expected 9 chars 1 done", obsQ.size(), doneCnt);
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            logic [8:0] o, e;
            o = obsQ.pop_front(); e = expQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL held_snapshot: got %h expected %h", o, e); end
        end
        @(negedge clk);
        checks++;
        if ({busyA, validA} !== 2'b00) begin
            errors++; $display("[TB] FAIL held_gap: got busy/valid %b expected 00", {busyA, validA});
        end
        expQ.delete();
        for (int i = 0; i < 9; i++) pushExp(c2[i], i == 8);
        applyStimulus(0, 1, 100, 60, 0, '0);
        startA = 1'b0;
        checks++;
        if (timedOut || obsQ.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL held_frame2: got %0d chars expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            logic [8:0] o, e;
            o = obsQ.pop_front(); e = expQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL held_frame2_char: got %h expected %h", o, e); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL held_idle: got busy %b expected 0", busyA); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        wordsA = 32'h00AF_1234; startA = 1'b1;
        applyStimulus(0, 0, 3, 60, 0, '0);
        checks++;
        if (obsQ.size() !== 3) begin errors++; $display("[TB] FAIL rst_prefix: got %0d chars expected 3", obsQ.size()); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({validA, busyA, doneA} !== 3'b000) begin
            errors++; $display("[TB] FAIL rst_abort: got valid/busy/done %b expected 000", {validA, busyA, doneA});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({validA, busyA, doneA} !== 3'b000) begin
            errors++; $display("[TB] FAIL rst_nodone: got valid/busy/done %b expected 000", {validA, busyA, doneA});
        end
        startA = 1'b1;
        queueFrame1();
        applyStimulus(0, 0, 100, 60, 0, '0);
        checks++;
        if (timedOut || obsQ.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL rst_refresh_count: got %0d expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            logic [8:0] o, e;
            o = obsQ.pop_front(); e = expQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL rst_refresh_char: got %h expected %h", o, e); end
        end
    endtask

    // Narrow lowercase instance: the whole frame is compared as it streams.
    task automatic test_param_sweep();
        logic [7:0] c [8] = '{8'h66, 8'h65, 8'h30, 8'h39, 8'h31, 8'h30, 8'h63, 8'h33};
        bit finished;
        int got;
        @(negedge clk);
        wordsB = 32'hC3_10_09_FE; blankB = 1'b0; startB = 1'b1; readyB = 1'b1;
        expQ.delete();
        for (int i = 0; i < 8; i++) pushExp(c[i], i == 7);
        finished = 0; got = 0;
        for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
            @(negedge clk);
            startB = 1'b0;
            if (validB && readyB) begin
                logic [8:0] e;
                got++;
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checks++;
                    if ({lastB, upB, lowB} !== e) begin
                        errors++; $display("[TB] FAIL sweep_char: got %h expected %h", {lastB, upB, lowB}, e);
                    end
                end
            end
            if (doneB) finished = 1;
        end
        checks++;
        if (!finished || got !== 8) begin
            errors++; $display("[TB] FAIL sweep_count: got %0d chars done=%0d expected 8 chars done=1", got, finished);
        end
    endtask

    // Top-level sequence; every test leaves both instances idle.
    initial begin
        startA = 0; blankA = 0; readyA = 1; wordsA = '0;
        startB = 0; blankB = 0; readyB = 1; wordsB = '0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_blanking();
        test_backpressure();
        test_start_held();
        test_mid_reset();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
